qoi_enc_ctrl: RTL

Sequencer that drives the QOI encoder peripheral's 8-register byte bus on behalf of a streaming pixel source and an encoded-byte sink. It programs the pixel count, starts the encoder, polls its status register, and feeds each RGBA pixel as four byte writes. It drains encoded bytes by reading register 0 until the encoder asks for the next pixel. It sits between a pixel DMA/stream on one side and the encoder's `cs/we/addr/data` port on the other, replacing CPU polling of the encoder.

---
 rtl/qoi_enc_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/qoi_enc_ctrl.sv
// Bus sequencer for the QOI encoder peripheral: programs size, starts, polls status, feeds RGBA pixels, drains bytes.
// Define QOI_CTRL_TIMEOUT_EN to add a poll timeout that raises the sticky err flag.
module qoi_enc_ctrl #(
    parameter int POLL_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic [29:0] cfg_size,
    output logic        busy,
    output logic        done,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [31:0] px_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        enc_cs,
    output logic        enc_we,
    output logic [2:0]  enc_addr,
    output logic [7:0]  enc_wdata,
    input  logic [7:0]  enc_rdata,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, CFG, POLL, FEED, DRAIN, HOLD, DONE} state_t;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_CTRL = 3'd3;
    localparam logic [2:0] REG_SIZE = 3'd4;

    state_t      state, state_nx;
    logic [29:0] size_q, px_cnt;
    logic [2:0]  step;
    logic [31:0] pixel_q;
    logic [31:0] size_word;
    logic [7:0]  out_q;
    logic        r_flag, w_flag, timeout_hit;

    assign r_flag    = enc_rdata[0];
    assign w_flag    = enc_rdata[1];
    assign size_word = {2'b00, size_q};
    assign out_data  = out_q;

`ifdef QOI_CTRL_TIMEOUT_EN
    localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

    logic [PW-1:0] poll_cnt;
    logic          err_q;

    // Counts consecutive polls that saw neither flag; the limit-th such poll aborts.
    assign timeout_hit = (state == POLL) && !r_flag && !w_flag && (poll_cnt == PW'(POLL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE && cfg_start) begin
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == POLL) begin
            if (r_flag || w_flag || timeout_hit) poll_cnt <= '0;
            else                                 poll_cnt <= poll_cnt + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic [31:0] unused_poll_limit;
    assign unused_poll_limit = 32'(POLL_LIMIT);
    assign timeout_hit       = 1'b0;
    assign err               = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            size_q  <= '0;
            px_cnt  <= '0;
            step    <= '0;
            pixel_q <= '0;
            out_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cfg_start && cfg_size != 30'd0) begin
                        size_q <= cfg_size;
                        px_cnt <= '0;
                        step   <= '0;
                    end
                end
                CFG: step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
                FEED: begin
                    if (step == 3'd0) begin
                        if (px_valid) begin
                            pixel_q <= px_data;
                            step    <= 3'd1;
                        end
                    end else if (step == 3'd3) begin
                        step   <= 3'd0;
                        px_cnt <= px_cnt + 30'd1;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                DRAIN: out_q <= enc_rdata;
                default: ;
            endcase
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        px_ready  = 1'b0;
        out_valid = 1'b0;
        enc_cs    = 1'b0;
        enc_we    = 1'b0;
        enc_addr  = 3'd0;
        enc_wdata = 8'h00;
        case (state)
            IDLE: begin
                if (cfg_start) state_nx = (cfg_size == 30'd0) ? DONE : CFG;
            end
            CFG: begin
                busy   = 1'b1;
                enc_cs = 1'b1;
                enc_we = 1'b1;
                if (step == 3'd4) begin
                    enc_addr  = REG_CTRL;
                    enc_wdata = 8'h80;
                    state_nx  = POLL;
                end else begin
                    enc_addr  = REG_SIZE + step;
                    enc_wdata = size_word[{step[1:0], 3'b000} +: 8];
                end
            end
            POLL: begin
                busy     = 1'b1;
                enc_cs   = 1'b1;
                enc_addr = REG_CTRL;
                if (r_flag)           state_nx = (px_cnt == size_q) ? DONE : FEED;
                else if (w_flag)      state_nx = DRAIN;
                else if (timeout_hit) state_nx = IDLE;
            end
            FEED: begin
                busy = 1'b1;
                if (step == 3'd0) begin
                    // The red byte goes out in the same cycle the pixel is accepted.
                    px_ready = 1'b1;
                    if (px_valid) begin
                        enc_cs    = 1'b1;
                        enc_we    = 1'b1;
                        enc_addr  = REG_DATA;
                        enc_wdata = px_data[7:0];
                    end
                end else begin
                    enc_cs    = 1'b1;
                    enc_we    = 1'b1;
                    enc_addr  = REG_DATA;
                    enc_wdata = pixel_q[{step[1:0], 3'b000} +: 8];
                    if (step == 3'd3) state_nx = POLL;
                end
            end
            DRAIN: begin
                busy     = 1'b1;
                enc_cs   = 1'b1;
                enc_addr = REG_DATA;
                state_nx = HOLD;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = POLL;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
